rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port arbiter and scheduler for the 32×32 register file. It accepts writeback requests from two producers, the ALU and the load unit, over valid/ready handshakes. Each source has a one-entry holding slot, and the arbiter drives the register file's single write port with one commit per cycle. It also exports a pending-write mask so issue logic can stall on registers with an uncommitted result.

## Interface
- DATA_W, 32: writeback data width.
- ADDR_W, 5: register address width. NREG = 2**ADDR_W.
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle when high together with alu_valid.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid, mem_ready, mem_addr, mem_data: same meaning, for the load unit.
- we  out  1  register-file write enable.
- writeA3  out  ADDR_W  register-file write address.
- data  out  DATA_W  register-file write data.
- pend_mask  out  NREG  bit i high while a slot holds an uncommitted write to register i. Bit 0 is always 0.

## Operation
- Each slot holds these registered fields: v, addr, data, and seq (accept order).
- Accept on an edge where src_valid && src_ready.
  - addr == 0: the request is consumed and discarded. The slot is not loaded, and x0 stays hardwired zero.
  - addr != 0: the slot is loaded.
- src_ready = !slot.v || slot granted this cycle. It depends only on state and the grant, never on src_valid.
- Grant, evaluated combinationally from slot state each cycle:
  - Neither slot valid: no grant, we = 0.
  - One slot valid: grant it.
  - Both valid, accepted on different edges: the older slot wins.
  - Both valid, accepted on the same edge, same addr: ALU wins, so the load result overwrites it one cycle later.
  - Both valid, accepted on the same edge, different addr: round-robin pointer rr wins. rr flips to the other source after every grant made while both slots were valid.
- Commit: we = 1, writeA3/data = the granted slot's addr/data. The granted slot clears on the edge unless it is reloaded on the same edge.
- Age tracking: one flop, alu_first. On an edge where exactly one slot is newly loaded while the other stays valid, the other is marked older. A same-edge load of both sets the tie flag.
- pend_mask = onehot(alu.addr) & alu.v | onehot(mem.addr) & mem.v.
- Simultaneous grant and reload of the same slot is legal, giving back-to-back throughput of one write per cycle per source when uncontended.

## Timing
- Reset (rst_n low at an edge):
  - Both slots invalid, rr = ALU, alu_first = 0.
  - Outputs the following cycle: we = 0, writeA3 = 0, data = 0, pend_mask = 0, alu_ready = mem_ready = 1.
  - Any write held at reset is dropped, never committed.
  - Reset overrides any accept on the same edge.
- Latency: request accepted at edge N, then we is high in cycle N+1, and the register file updates at edge N+1. Under contention the loser commits in cycle N+2.
- Worst-case occupancy is 2 cycles. No request waits more than one extra cycle.
- Throughput: two simultaneous producers give sustained 1 commit/cycle. Each producer then sees ready low every other cycle.
- pend_mask bits set in the cycle after acceptance and clear in the cycle after commit. Issue logic reading the register file in the commit cycle must still stall, since there is no bypass.

## Structure
- Shared package rf_pkg: DATA_W/ADDR_W defaults, NREG, the src_e enum (SRC_ALU, SRC_MEM), and the wb_slot_t struct (v, addr, data).
- One natural sub-module, wb_slot: a single holding slot with load/clear/ready logic, instantiated twice.
- Grant, age and rr logic lives in the top level.
- The register file itself is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-operation: load both slots (ALU x5=0x11, MEM x6=0x22), then assert rst_n low one cycle. Required: no we in the following cycle, pend_mask = 0, and x5/x6 unchanged.
- Single ALU write: x3 = 0xDEADBEEF accepted at edge N. Required: we = 1, writeA3 = 3, data = 0xDEADBEEF in cycle N+1, and pend_mask[3] high only in cycle N+1.
- Same-cycle, same-address contention: ALU x7=0xA and MEM x7=0xB. Required: ALU commits first (cycle N+1), MEM commits in N+2, and mem_ready is low in cycle N+1. Final x7 = 0xB.
- Age ordering: MEM x9=1 accepted at edge N while ALU is stalled, then ALU x9=2 at edge N+1. Required: MEM commits in N+1 and ALU in N+2, final x9 = 2.
- x0 discard: ALU x0=0xFFFF with valid high. Required: alu_ready = 1, no we ever asserted, pend_mask stays 0.
- Sustained contention: both sources valid with distinct addresses for 8 cycles. Required: exactly one commit per cycle, grants alternate, and no request waits more than 2 cycles.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file writeback arbiter.
//   DATA_W / ADDR_W : writeback data and register address widths
//   NREG            : number of architectural registers (2**ADDR_W)
//   src_e           : writeback producer identifier
//   wb_slot_t       : contents of one holding slot
//   onehot()        : register address to pending-mask bit
package rf_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2**ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_slot_t;

   function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
      onehot    = '0;
      onehot[a] = 1'b1;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: valid/ready writeback request channel from one producer.
//   valid : producer has a result to write back
//   ready : arbiter accepts the request this cycle (valid && ready)
//   addr  : destination register
//   data  : result value
// master = producer side, slave = arbiter side.
interface rf_wb_arbiter_if;
   import rf_pkg::*;

   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (output valid, output addr, output data, input ready);
   modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/wb_slot.sv
// wb_slot: one-entry holding slot for a single writeback producer.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request channel from the producer (slave side)
//   grant      : the slot's content is committed this cycle
//   slot       : registered slot contents (v, addr, data)
//   load       : the slot is (re)loaded on the coming edge
// Requests to x0 are accepted but never stored, so x0 stays zero and never
// shows up as pending.
module wb_slot
   import rf_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   rf_wb_arbiter_if.slave req,
   input  logic     grant,
   output wb_slot_t slot,
   output logic     load
);

   wb_slot_t slot_q;
   wb_slot_t slot_d;
   logic     ready;

   // Free slot, or one being drained this cycle, can take a new request;
   // valid is deliberately not part of this so ready never loops back.
   assign ready     = !slot_q.v || grant;
   assign req.ready = ready;

   // NOTE: slot_d takes its hold value before any condition, so every path
   // assigns it and no latch is inferred.
   always_comb begin
      slot_d = slot_q;
      load   = req.valid && ready && (req.addr != '0);
      if (grant) begin
         slot_d.v = 1'b0;
      end
      // A reload on the grant edge wins over the clear: back-to-back writes.
      if (load) begin
         slot_d.v    = 1'b1;
         slot_d.addr = req.addr;
         slot_d.data = req.data;
      end
   end

   // NOTE: state flops use non-blocking assignments only, so every flop in
   // the design samples pre-edge values regardless of block ordering.
   // NOTE: the payload is reset along with v so the idle write port and
   // pend_mask read as clean zeros straight out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: schedules ALU and load-unit writebacks onto the single
// register-file write port, one commit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   alu, mem   : writeback request channels (slave side)
//   we         : register-file write enable
//   writeA3    : register-file write address (0 when idle)
//   data       : register-file write data (0 when idle)
//   pend_mask  : bit i set while a slot holds an uncommitted write to x(i)
// Grant priority when both slots hold a write: the older one; on a same-edge
// tie the ALU for equal addresses (the load result then lands last), else
// the round-robin pointer.
module rf_wb_arbiter
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   rf_wb_arbiter_if.slave    alu,
   rf_wb_arbiter_if.slave    mem,
   output logic              we,
   output logic [ADDR_W-1:0] writeA3,
   output logic [DATA_W-1:0] data,
   output logic [NREG-1:0]   pend_mask
);

   wb_slot_t alu_slot;
   wb_slot_t mem_slot;
   logic     alu_load;
   logic     mem_load;
   logic     alu_grant;
   logic     mem_grant;
   logic     gnt_valid;
   src_e     gnt_src;
   logic     both_v;

   src_e     rr_q, rr_d;
   logic     alu_first_q, alu_first_d;
   logic     tie_q, tie_d;

   wb_slot u_alu_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (alu),
      .grant (alu_grant),
      .slot  (alu_slot),
      .load  (alu_load)
   );

   wb_slot u_mem_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (mem),
      .grant (mem_grant),
      .slot  (mem_slot),
      .load  (mem_load)
   );

   assign both_v = alu_slot.v && mem_slot.v;

   // Grant. Suppressed while rst_n is low so a write still held when reset
   // arrives is dropped instead of reaching the register file.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_src   = SRC_ALU;
      if (rst_n) begin
         if (both_v) begin
            gnt_valid = 1'b1;
            if (tie_q) begin
               gnt_src = (alu_slot.addr == mem_slot.addr) ? SRC_ALU : rr_q;
            end else begin
               gnt_src = alu_first_q ? SRC_ALU : SRC_MEM;
            end
         end else if (alu_slot.v) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_ALU;
         end else if (mem_slot.v) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_MEM;
         end
      end
      alu_grant = gnt_valid && (gnt_src == SRC_ALU);
      mem_grant = gnt_valid && (gnt_src == SRC_MEM);
   end

   // Age and round-robin bookkeeping. Both slots can only be valid together
   // after a same-edge load (tie) or after one loads while the other waits,
   // so these two cases fully define the order whenever it matters.
   always_comb begin
      alu_first_d = alu_first_q;
      tie_d       = tie_q;
      rr_d        = rr_q;
      if (alu_load && mem_load) begin
         tie_d = 1'b1;
      end else if (alu_load && mem_slot.v && !mem_grant) begin
         alu_first_d = 1'b0;
         tie_d       = 1'b0;
      end else if (mem_load && alu_slot.v && !alu_grant) begin
         alu_first_d = 1'b1;
         tie_d       = 1'b0;
      end
      if (both_v && gnt_valid) begin
         rr_d = (gnt_src == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q        <= SRC_ALU;
         alu_first_q <= 1'b0;
         tie_q       <= 1'b0;
      end else begin
         rr_q        <= rr_d;
         alu_first_q <= alu_first_d;
         tie_q       <= tie_d;
      end
   end

   // Write port and pending mask.
   always_comb begin
      we        = gnt_valid;
      writeA3   = '0;
      data      = '0;
      if (alu_grant) begin
         writeA3 = alu_slot.addr;
         data    = alu_slot.data;
      end else if (mem_grant) begin
         writeA3 = mem_slot.addr;
         data    = mem_slot.data;
      end
      pend_mask = (alu_slot.v ? onehot(alu_slot.addr) : '0)
                | (mem_slot.v ? onehot(mem_slot.addr) : '0);
      pend_mask[0] = 1'b0;
   end

endmodule
